// File: rtl/hub75_row_fetch.sv
// hub75_row_fetch: walks one panel row through the pixel store B port and streams one bitplane per column.
// Ports: clk/reset (async, active-high); start/row_addr/plane command, busy/done status;
//   mem_addr/mem_en/mem_q read port of the store (MEM_LATENCY cycles from enable to data);
//   pixel_valid/pixel_ready handshake carrying rgb_top/rgb_bot ({r,g,b}) and pixel_last.
// Define HUB75_ROW_FETCH_REVERSE_EN to walk columns from PIXEL_WIDTH-1 down to 0.
module hub75_row_fetch #(
  parameter int PIXEL_WIDTH = 64,
  parameter int PIXEL_HALFHEIGHT = 16,
  parameter int MEM_LATENCY = 1,
  localparam int RW = $clog2(PIXEL_HALFHEIGHT),
  localparam int CW = $clog2(PIXEL_WIDTH),
  localparam int AW = RW + CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [RW-1:0] row_addr,
  input  logic [2:0]    plane,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  input  logic [31:0]   mem_q,
  output logic          pixel_valid,
  input  logic          pixel_ready,
  output logic [2:0]    rgb_top,
  output logic [2:0]    rgb_bot,
  output logic          pixel_last
);
  localparam int D = MEM_LATENCY + 1;
  localparam int PW = D > 1 ? $clog2(D) : 1;
  localparam int NW = $clog2(D + 1);
`ifdef HUB75_ROW_FETCH_REVERSE_EN
  localparam logic [CW-1:0] COL_FIRST = CW'(PIXEL_WIDTH - 1);
  localparam logic [CW-1:0] COL_END = '0;
  localparam logic [CW-1:0] COL_STEP = '1;
`else
  localparam logic [CW-1:0] COL_FIRST = '0;
  localparam logic [CW-1:0] COL_END = CW'(PIXEL_WIDTH - 1);
  localparam logic [CW-1:0] COL_STEP = CW'(1);
`endif
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_n;
  logic [RW-1:0] row_r;
  logic [2:0] plane_r;
  logic [CW-1:0] col;
  logic [AW-1:0] addr_q;
  logic [MEM_LATENCY-1:0] pipe, pipe_last;
  logic [6:0] fifo [D];
  logic [6:0] head;
  logic [PW-1:0] wp, rp;
  logic [NW-1:0] cnt;
  logic [7:0] occ;
  logic issue, pop, push, done_n;
  // Field bit `pl` of an RGB565 word; G drops its LSB so G[4:0] sits at [10:6].
  function automatic logic [2:0] px_bits(input logic [15:0] px, input logic [2:0] pl);
    return pl > 3'd4 ? 3'b000 : {px[{1'b0, pl} + 4'd11], px[{1'b0, pl} + 4'd6], px[{1'b0, pl}]};
  endfunction
  assign pixel_valid = cnt != '0;
  assign head = fifo[rp];
  assign pixel_last = pixel_valid & head[6];
  assign rgb_top = pixel_valid ? head[5:3] : 3'b000;
  assign rgb_bot = pixel_valid ? head[2:0] : 3'b000;
  assign busy = state != IDLE;
  assign push = pipe[MEM_LATENCY-1];
  always_comb begin
    pop = pixel_valid & pixel_ready;
    // Buffered plus in-flight words, net of this cycle's pop, must leave room for one more.
    occ = 8'(cnt) - 8'(pop);
    for (int i = 0; i < MEM_LATENCY; i++) occ = occ + 8'(pipe[i]);
    state_n = state;
    issue = 1'b0;
    case (state)
      IDLE: state_n = start ? FETCH : IDLE;
      FETCH: begin
        issue = occ < 8'(D);
        state_n = issue && col == COL_END ? DRAIN : FETCH;
      end
      DRAIN: state_n = pop && head[6] ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
    mem_en = issue;
    mem_addr = issue ? {row_r, col} : addr_q;
    done_n = state == DRAIN && pop && head[6];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_r <= '0;
      plane_r <= '0;
      col <= '0;
      addr_q <= '0;
      pipe <= '0;
      pipe_last <= '0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        row_r <= row_addr;
        plane_r <= plane;
        col <= COL_FIRST;
      end
      if (issue) begin
        addr_q <= {row_r, col};
        if (col != COL_END) col <= col + COL_STEP;
      end
      pipe <= (pipe << 1) | MEM_LATENCY'(issue);
      pipe_last <= (pipe_last << 1) | MEM_LATENCY'(issue && col == COL_END);
      if (push) wp <= wp == PW'(D - 1) ? '0 : wp + PW'(1);
      if (pop) rp <= rp == PW'(D - 1) ? '0 : rp + PW'(1);
      cnt <= cnt + NW'(push) - NW'(pop);
      done <= done_n;
    end
  end
  always_ff @(posedge clk) begin
    if (push) fifo[wp] <= {pipe_last[MEM_LATENCY-1], px_bits({mem_q[7:0], mem_q[15:8]}, plane_r), px_bits({mem_q[23:16], mem_q[31:24]}, plane_r)};
  end
endmodule

// File: tb/tb_hub75_row_fetch.sv
// tb_hub75_row_fetch: directed bench for hub75_row_fetch with a one-cycle-latency store model.
module tb_hub75_row_fetch;
`ifdef HUB75_ROW_FETCH_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif
  logic clk = 0, reset = 1, start = 0, pixel_ready = 0;
  logic [3:0] row_addr = '0;
  logic [2:0] plane = '0;
  logic busy, done, mem_en, pixel_valid, pixel_last;
  logic [9:0] mem_addr;
  logic [31:0] mem_q = '0;
  logic [2:0] rgb_top, rgb_bot;
  logic [31:0] mem [0:1023];
  int errors = 0, checks = 0, cyc = 0, c0 = -100;
  logic [9:0] addr_q [$];
  logic [6:0] pix_q [$];
  logic [11:0] snap1;
  logic [7:0] held;
  bit stalled;
  int first_valid, last_cyc, done_cyc, done_cnt, outst, max_outst, stall_seen, stall_bad;

  hub75_row_fetch dut (
    .clk(clk), .reset(reset), .start(start), .row_addr(row_addr), .plane(plane),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_en(mem_en), .mem_q(mem_q),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .rgb_top(rgb_top), .rgb_bot(rgb_bot), .pixel_last(pixel_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_en) mem_q <= mem[mem_addr];

  always @(negedge clk) begin
    if (reset) begin
      outst = 0;
      stalled = 0;
    end else begin
      if (cyc == c0 + 1) snap1 = {busy, mem_en, mem_addr};
      if (mem_en) addr_q.push_back(mem_addr);
      if (pixel_valid && first_valid < 0) first_valid = cyc;
      if (stalled) begin
        stall_seen++;
        if ({pixel_valid, pixel_last, rgb_top, rgb_bot} !== held) stall_bad++;
      end
      stalled = pixel_valid && !pixel_ready;
      held = {pixel_valid, pixel_last, rgb_top, rgb_bot};
      if (pixel_valid && pixel_ready) begin
        pix_q.push_back({pixel_last, rgb_top, rgb_bot});
        if (pixel_last) last_cyc = cyc;
      end
      outst = outst + int'(mem_en) - int'(pixel_valid && pixel_ready);
      if (outst > max_outst) max_outst = outst;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Column c encoded into plane-0 bits: sp0 carries c[5:3] on R/G/B, sp1 carries c[2:0].
  function automatic logic [31:0] enc(input logic [5:0] c);
    logic [15:0] s0, s1;
    s0 = {4'b0, c[5], 4'b0, c[4], 5'b0, c[3]};
    s1 = {4'b0, c[2], 4'b0, c[1], 5'b0, c[0]};
    return {s1[7:0], s1[15:8], s0[7:0], s0[15:8]};
  endfunction

  function automatic logic [5:0] col_of(input int i);
    return REV ? 6'(63 - i) : 6'(i);
  endfunction

  task automatic clear;
    addr_q.delete();
    pix_q.delete();
    first_valid = -1;
    last_cyc = -1;
    done_cyc = -1;
    done_cnt = 0;
    outst = 0;
    max_outst = 0;
    stall_seen = 0;
    stall_bad = 0;
    snap1 = '0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input logic [3:0] r, input logic [2:0] p, input int pat, input int glitch, output bit ok);
    clear();
    tick();
    start = 1;
    row_addr = r;
    plane = p;
    pixel_ready = 1;
    c0 = cyc;
    ok = 0;
    for (int k = 1; k < 400 && !ok; k++) begin
      tick();
      start = (k == glitch);
      if (k == glitch) begin
        row_addr = 4'd5;
        plane = 3'd2;
      end
      pixel_ready = pat == 0 || k % 4 == 0 || k % 4 == 3;
      ok = done_cnt > 0;
    end
    start = 0;
    pixel_ready = 1;
    repeat (4) tick();
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, mem_en, pixel_valid, pixel_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_en, pixel_valid, pixel_last});
    end
    checks++;
    if ({rgb_top, rgb_bot} !== 6'b0) begin
      errors++;
      $display("FAIL reset_rgb: got %b want 000000", {rgb_top, rgb_bot});
    end
    checks++;
    if (mem_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_addr: got %0h want 0", mem_addr);
    end
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_basic;
    bit ok;
    int bad;
    for (int c = 0; c < 64; c++) mem[{4'd3, 6'(c)}] = 32'h1F0000F8;
    run_row(4'd3, 3'd4, 0, -1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout: got no done want done");
    end
    checks++;
    if (snap1 !== {1'b1, 1'b1, 4'd3, col_of(0)}) begin
      errors++;
      $display("FAIL basic_cycle1: got %0h want %0h", snap1, {1'b1, 1'b1, 4'd3, col_of(0)});
    end
    checks++;
    if (first_valid - c0 !== 3) begin
      errors++;
      $display("FAIL basic_first_valid: got %0d want 3", first_valid - c0);
    end
    checks++;
    if (last_cyc - c0 !== 66) begin
      errors++;
      $display("FAIL basic_last_cycle: got %0d want 66", last_cyc - c0);
    end
    checks++;
    if (done_cyc - c0 !== 67) begin
      errors++;
      $display("FAIL basic_done_cycle: got %0d want 67", done_cyc - c0);
    end
    bad = 0;
    foreach (pix_q[i]) if (pix_q[i] !== {i == 63, 3'b100, 3'b001}) bad++;
    checks++;
    if (pix_q.size() != 64 || bad != 0) begin
      errors++;
      $display("FAIL basic_pixels: got %0d pixels %0d wrong want 64 pixels 0 wrong", pix_q.size(), bad);
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done_cnt=%0d busy=%b want 1 0", done_cnt, busy);
    end
    for (int c = 0; c < 64; c++) mem[{4'd3, 6'(c)}] = enc(6'(c));
  endtask

  task automatic test_plane;
    bit ok;
    int bad;
    logic [2:0] pl;
    logic [2:0] want;
    for (int c = 0; c < 64; c++) mem[{4'd2, 6'(c)}] = 32'hE007E007;
    for (int j = 0; j < 6; j++) begin
      pl = j < 5 ? 3'(j) : 3'd6;
      want = j < 5 ? 3'b010 : 3'b000;
      run_row(4'd2, pl, 0, -1, ok);
      bad = 0;
      foreach (pix_q[i]) if (pix_q[i][5:0] !== {want, want}) bad++;
      checks++;
      if (!ok || pix_q.size() != 64 || bad != 0) begin
        errors++;
        $display("FAIL plane_%0d: got done=%b %0d pixels %0d wrong want done 64 pixels rgb %b", pl, ok, pix_q.size(), bad, want);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int bad, abad;
    run_row(4'd3, 3'd0, 1, -1, ok);
    bad = 0;
    abad = 0;
    foreach (pix_q[i]) if (pix_q[i] !== {i == 63, col_of(i)}) bad++;
    foreach (addr_q[i]) if (addr_q[i] !== {4'd3, col_of(i)}) abad++;
    checks++;
    if (!ok || pix_q.size() != 64 || bad != 0) begin
      errors++;
      $display("FAIL bp_pixels: got done=%b %0d pixels %0d wrong want done 64 pixels 0 wrong", ok, pix_q.size(), bad);
    end
    checks++;
    if (addr_q.size() != 64 || abad != 0) begin
      errors++;
      $display("FAIL bp_addrs: got %0d reads %0d wrong want 64 reads 0 wrong", addr_q.size(), abad);
    end
    checks++;
    if (max_outst > 2) begin
      errors++;
      $display("FAIL bp_credit: got max outstanding %0d want <=2", max_outst);
    end
    checks++;
    if (stall_seen == 0 || stall_bad != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d stalls %0d unstable want >0 stalls 0 unstable", stall_seen, stall_bad);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL bp_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_ignored_start;
    bit ok;
    int bad, abad;
    run_row(4'd3, 3'd0, 0, 10, ok);
    bad = 0;
    abad = 0;
    foreach (pix_q[i]) if (pix_q[i] !== {i == 63, col_of(i)}) bad++;
    foreach (addr_q[i]) if (addr_q[i] !== {4'd3, col_of(i)}) abad++;
    checks++;
    if (addr_q.size() != 64 || abad != 0) begin
      errors++;
      $display("FAIL ign_addrs: got %0d reads %0d wrong want 64 reads 0 wrong", addr_q.size(), abad);
    end
    checks++;
    if (!ok || pix_q.size() != 64 || bad != 0) begin
      errors++;
      $display("FAIL ign_pixels: got %0d pixels %0d wrong want 64 pixels 0 wrong", pix_q.size(), bad);
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_done: got done_cnt=%0d busy=%b want 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int bad, abad;
    clear();
    tick();
    start = 1;
    row_addr = 4'd3;
    plane = 3'd0;
    pixel_ready = 1;
    c0 = cyc;
    tick();
    start = 0;
    for (int k = 0; k < 100 && addr_q.size() < 21; k++) tick();
    checks++;
    if (addr_q.size() != 21) begin
      errors++;
      $display("FAIL mid_reach_col20: got %0d reads want 21", addr_q.size());
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_en, pixel_valid, pixel_last, rgb_top, rgb_bot, mem_addr} !== 21'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %0h want 0", {busy, done, mem_en, pixel_valid, pixel_last, rgb_top, rgb_bot, mem_addr});
    end
    tick();
    reset = 0;
    @(negedge clk);
    checks++;
    if ({busy, mem_en, pixel_valid} !== 3'b0) begin
      errors++;
      $display("FAIL mid_idle: got %b want 000", {busy, mem_en, pixel_valid});
    end
    run_row(4'd7, 3'd0, 0, -1, ok);
    bad = 0;
    abad = 0;
    foreach (pix_q[i]) if (pix_q[i] !== {i == 63, col_of(i)}) bad++;
    foreach (addr_q[i]) if (addr_q[i] !== {4'd7, col_of(i)}) abad++;
    checks++;
    if (!ok || pix_q.size() != 64 || bad != 0) begin
      errors++;
      $display("FAIL mid_rerun_pixels: got %0d pixels %0d wrong want 64 pixels 0 wrong", pix_q.size(), bad);
    end
    checks++;
    if (addr_q.size() != 64 || abad != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL mid_rerun_addrs: got %0d reads %0d wrong %0d done want 64 0 1", addr_q.size(), abad, done_cnt);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = enc(6'(a));
    for (int c = 0; c < 64; c++) mem[{4'd5, 6'(c)}] = 32'h0;
    clear();
    test_reset();
    test_basic();
    test_plane();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
